// File: rtl/chrom_eval_pkg.sv
// rtl/chrom_eval_pkg.sv - shared state encoding and widths for the chromosome evaluation sequencer
package chrom_eval_pkg;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_ARM       = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ACK       = 3'd4,
        ST_SUM       = 3'd5,
        ST_REPORT    = 3'd6
    } state_e;

    localparam int CHROM_BITS  = 992;
    localparam int CHROM_SUM_W = 32;
    // Eight lanes add at most three bits of growth.
    localparam int FITNESS_W   = CHROM_SUM_W + 3;

endpackage

// File: rtl/chromosome_eval_sequencer_error_sum_reducer.sv
// rtl/chromosome_eval_sequencer_error_sum_reducer.sv - combinational reduction of the per-output error sums
module error_sum_reducer
    import chrom_eval_pkg::*;
#(
    parameter int NUM_OUTS = 8,
    parameter int SUM_W    = 32,
    parameter int OUT_W    = FITNESS_W
) (
    input  logic [NUM_OUTS-1:0][SUM_W-1:0] sums_i,
    output logic [OUT_W-1:0]               total_o
);

    // Each lane is zero-extended before adding so the total never wraps.
    always_comb begin
        total_o = '0;
        for (int i = 0; i < NUM_OUTS; i++) begin
            total_o = total_o + OUT_W'(sums_i[i]);
        end
    end

endmodule

// File: rtl/chromosome_eval_sequencer.sv
// rtl/chromosome_eval_sequencer.sv - descriptor loader, evaluation handshake and fitness reporter; watchdog under CHROM_EVAL_WATCHDOG_EN
module chromosome_eval_sequencer
    import chrom_eval_pkg::*;
#(
    parameter int WORD_W          = 32,
    parameter int CHROM_WORDS     = 31,
    parameter int NUM_OUTS        = 8,
    parameter int SUM_W           = 32,
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input  logic                           iClock,
    input  logic                           iReset_n,
    input  logic                           iWordValid,
    input  logic [WORD_W-1:0]              iWordData,
    output logic                           oWordReady,
    input  logic                           iLoadRestart,
    output logic [CHROM_BITS-1:0]          oChromDescription,
    input  logic                           iReadyToProcess,
    output logic                           oStartProcessing,
    input  logic                           iDoneProcessing,
    output logic                           oDoneProcessingFeedback,
    input  logic [NUM_OUTS-1:0][SUM_W-1:0] iErrorSums,
    output logic [NUM_OUTS-1:0][SUM_W-1:0] oErrorSums,
    output logic [FITNESS_W-1:0]           oFitness,
    output logic                           oPerfect,
    output logic                           oTimeout,
    output logic                           oResultValid,
    input  logic                           iResultAck,
    output logic [2:0]                     oState
);

    localparam int              CNT_W     = $clog2(CHROM_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(CHROM_WORDS - 1);

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic [CHROM_BITS-1:0]          desc_q, desc_d;
    logic [NUM_OUTS-1:0][SUM_W-1:0] sums_q, sums_d;
    logic [FITNESS_W-1:0]           fitness_q, fitness_d;
    logic                           perfect_q, perfect_d;
    logic [FITNESS_W-1:0]           total;

    error_sum_reducer #(
        .NUM_OUTS (NUM_OUTS),
        .SUM_W    (SUM_W),
        .OUT_W    (FITNESS_W)
    ) u_reducer (
        .sums_i  (sums_q),
        .total_o (total)
    );

`ifdef CHROM_EVAL_WATCHDOG_EN
    localparam logic [31:0] WD_LAST = 32'(WATCHDOG_CYCLES - 1);
    logic [31:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        desc_d    = desc_q;
        sums_d    = sums_q;
        fitness_d = fitness_q;
        perfect_d = perfect_q;
`ifdef CHROM_EVAL_WATCHDOG_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_LOAD: begin
                // A restart wins over a coincident word, which is dropped.
                if (iLoadRestart) begin
                    count_d = '0;
                end else if (iWordValid) begin
                    desc_d[count_q*WORD_W +: WORD_W] = iWordData;
                    if (count_q == LAST_WORD) begin
                        count_d = '0;
                        state_d = ST_ARM;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (iReadyToProcess) begin
                    state_d = ST_START;
`ifdef CHROM_EVAL_WATCHDOG_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
`ifdef CHROM_EVAL_WATCHDOG_EN
                wd_d = '0;
`endif
            end
            ST_WAIT_DONE: begin
                if (iDoneProcessing) begin
                    sums_d  = iErrorSums;
                    state_d = ST_ACK;
`ifdef CHROM_EVAL_WATCHDOG_EN
                end else if (wd_q == WD_LAST) begin
                    // Stuck processing stage: report a worst-possible result.
                    timeout_d = 1'b1;
                    sums_d    = '1;
                    fitness_d = '1;
                    perfect_d = 1'b0;
                    state_d   = ST_REPORT;
                end else begin
                    wd_d = wd_q + 32'd1;
`endif
                end
            end
            ST_ACK: begin
                state_d = ST_SUM;
            end
            ST_SUM: begin
                fitness_d = total;
                perfect_d = (total == '0);
                state_d   = ST_REPORT;
            end
            ST_REPORT: begin
                if (iResultAck) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q   <= ST_LOAD;
            count_q   <= '0;
            desc_q    <= '0;
            sums_q    <= '0;
            fitness_q <= '0;
            perfect_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            desc_q    <= desc_d;
            sums_q    <= sums_d;
            fitness_q <= fitness_d;
            perfect_q <= perfect_d;
        end
    end

`ifdef CHROM_EVAL_WATCHDOG_EN
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign oTimeout = timeout_q;
`else
    assign oTimeout = 1'b0;
`endif

    assign oWordReady              = (state_q == ST_LOAD);
    assign oStartProcessing        = (state_q == ST_START);
    assign oDoneProcessingFeedback = (state_q == ST_ACK);
    assign oResultValid            = (state_q == ST_REPORT);
    assign oChromDescription       = desc_q;
    assign oErrorSums              = sums_q;
    assign oFitness                = fitness_q;
    assign oPerfect                = perfect_q;
    assign oState                  = state_q;

endmodule

// File: tb/tb_chromosome_eval_sequencer.sv
// tb/tb_chromosome_eval_sequencer.sv - scoreboard bench for chromosome_eval_sequencer
module tb_chromosome_eval_sequencer;

    logic              iClock = 1'b0;
    logic              iReset_n;
    logic              iWordValid;
    logic [31:0]       iWordData;
    logic              oWordReady;
    logic              iLoadRestart;
    logic [991:0]      oChromDescription;
    logic              iReadyToProcess;
    logic              oStartProcessing;
    logic              iDoneProcessing;
    logic              oDoneProcessingFeedback;
    logic [7:0][31:0]  iErrorSums;
    logic [7:0][31:0]  oErrorSums;
    logic [34:0]       oFitness;
    logic              oPerfect;
    logic              oTimeout;
    logic              oResultValid;
    logic              iResultAck;
    logic [2:0]        oState;

    chromosome_eval_sequencer #(.WATCHDOG_CYCLES(20)) dut (
        .iClock                  (iClock),
        .iReset_n                (iReset_n),
        .iWordValid              (iWordValid),
        .iWordData               (iWordData),
        .oWordReady              (oWordReady),
        .iLoadRestart            (iLoadRestart),
        .oChromDescription       (oChromDescription),
        .iReadyToProcess         (iReadyToProcess),
        .oStartProcessing        (oStartProcessing),
        .iDoneProcessing         (iDoneProcessing),
        .oDoneProcessingFeedback (oDoneProcessingFeedback),
        .iErrorSums              (iErrorSums),
        .oErrorSums              (oErrorSums),
        .oFitness                (oFitness),
        .oPerfect                (oPerfect),
        .oTimeout                (oTimeout),
        .oResultValid            (oResultValid),
        .iResultAck              (iResultAck),
        .oState                  (oState)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        logic [34:0] fit;
        logic        perf;
        logic        tmo;
        logic [31:0] l0;
        logic [31:0] l7;
    } res_t;

    res_t         res_q[$];
    logic [991:0] desc_q[$];
    int           errors = 0;
    int           checks = 0;
    int           n_starts = 0;
    int           n_fb = 0;
    bit           prev_valid = 0, prev_start = 0, prev_fb = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a start or a new result.
    always @(negedge iClock) begin
        if (!iReset_n) begin
            prev_valid = 0;
            prev_start = 0;
            prev_fb    = 0;
        end else begin
            if (oStartProcessing) begin
                n_starts++;
                chk("start_one_cycle", prev_start, 0);
                checks++;
                if (desc_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: got start expected none");
                end else begin
                    logic [991:0] e;
                    e = desc_q.pop_front();
                    if (oChromDescription !== e) begin
                        int k;
                        errors++;
                        for (k = 0; k < 31; k++)
                            if (oChromDescription[k*32 +: 32] !== e[k*32 +: 32]) break;
                        $display("FAIL desc_at_start word %0d: got %0h expected %0h",
                                 k, oChromDescription[k*32 +: 32], e[k*32 +: 32]);
                    end
                end
            end
            if (oDoneProcessingFeedback) begin
                n_fb++;
                chk("fb_one_cycle", prev_fb, 0);
            end
            if (oResultValid && !prev_valid) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got valid expected none");
                end else begin
                    res_t r;
                    checks--;
                    r = res_q.pop_front();
                    chk("fitness", oFitness, r.fit);
                    chk("perfect", oPerfect, r.perf);
                    chk("timeout", oTimeout, r.tmo);
                    chk("sum_lane0", oErrorSums[0], r.l0);
                    chk("sum_lane7", oErrorSums[7], r.l7);
                end
            end
            prev_valid = oResultValid;
            prev_start = oStartProcessing;
            prev_fb    = oDoneProcessingFeedback;
        end
    end

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic load_desc(input logic [31:0] base, input int n, input bit push);
        logic [991:0] e;
        e = '0;
        for (int k = 0; k < n; k++) begin
            iWordValid = 1;
            iWordData  = base + k;
            e[k*32 +: 32] = base + k;
            tick();
        end
        iWordValid = 0;
        if (push) desc_q.push_back(e);
    endtask

    task automatic wait_start(output bit seen);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (oStartProcessing) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk("start_seen", seen, 1);
    endtask

    task automatic run_eval(input logic [7:0][31:0] sums, input res_t exp);
        bit seen;
        iReadyToProcess = 1;
        wait_start(seen);
        if (!seen) return;
        res_q.push_back(exp);
        tick();
        tick();
        tick();
        iErrorSums      = sums;
        iDoneProcessing = 1;
        tick();
        iDoneProcessing = 0;
        iErrorSums      = '0;
        chk("fb_high", oDoneProcessingFeedback, 1);
        tick();
        chk("fb_low", oDoneProcessingFeedback, 0);
        tick();
        chk("valid_high", oResultValid, 1);
        repeat (4) tick();
        chk("valid_held", oResultValid, 1);
        iResultAck = 1;
        tick();
        iResultAck = 0;
        chk("valid_low_after_ack", oResultValid, 0);
        chk("ready_after_ack", oWordReady, 1);
        chk("fitness_held", oFitness, exp.fit);
        iReadyToProcess = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0][31:0] s;
        res_t             r;
        int               s0;
        bit               seen;

        iReset_n = 0; iWordValid = 0; iWordData = '0; iLoadRestart = 0;
        iReadyToProcess = 0; iDoneProcessing = 0; iErrorSums = '0; iResultAck = 0;
        repeat (3) tick();
        chk("rst_state", oState, 0);
        chk("rst_ready", oWordReady, 1);
        chk("rst_desc_lo", oChromDescription[63:0], 0);
        chk("rst_fitness", oFitness, 0);
        chk("rst_valid", oResultValid, 0);
        chk("rst_timeout", oTimeout, 0);
        iReset_n = 1;
        tick();

        // Plain load followed by sums 1..8.
        load_desc(32'h0100_0000, 31, 1);
        chk("ready_falls", oWordReady, 0);
        chk("state_arm", oState, 1);
        chk("desc_word0", oChromDescription[31:0], 32'h0100_0000);
        chk("desc_word30", oChromDescription[991:960], 32'h0100_001E);
        for (int i = 0; i < 8; i++) s[i] = i + 1;
        r = '{fit: 35'd36, perf: 0, tmo: 0, l0: 32'd1, l7: 32'd8};
        run_eval(s, r);

        // Restart with a coincident word, then a fresh full load.
        load_desc(32'hAA00_0000, 10, 0);
        iWordValid = 1; iWordData = 32'hDEAD_BEEF; iLoadRestart = 1;
        tick();
        iWordValid = 0; iLoadRestart = 0;
        s0 = n_starts;
        load_desc(32'h0200_0000, 31, 1);
        chk("restart_state_arm", oState, 1);
        s = '0;
        r = '{fit: 35'd0, perf: 1, tmo: 0, l0: 32'd0, l7: 32'd0};
        run_eval(s, r);
        chk("restart_one_start", n_starts, s0 + 1);

        // Saturated lanes.
        load_desc(32'h0500_0000, 31, 1);
        for (int i = 0; i < 8; i++) s[i] = 32'hFFFF_FFFF;
        r = '{fit: 35'h7_FFFF_FFF8, perf: 0, tmo: 0, l0: 32'hFFFF_FFFF, l7: 32'hFFFF_FFFF};
        run_eval(s, r);

        // Not-ready hold, then reset in the middle of WAIT_DONE.
        load_desc(32'h0300_0000, 31, 1);
        s0 = n_starts;
        repeat (50) tick();
        chk("no_start_not_ready", n_starts, s0);
        chk("hold_in_arm", oState, 1);
        iReadyToProcess = 1;
        wait_start(seen);
        tick();
        tick();
        chk("in_wait_done", oState, 3);
        iReset_n = 0;
        #1;
        chk("mid_rst_state", oState, 0);
        chk("mid_rst_ready", oWordReady, 1);
        chk("mid_rst_desc", oChromDescription[991:928], 0);
        chk("mid_rst_fitness", oFitness, 0);
        chk("mid_rst_sums", oErrorSums[7], 0);
        chk("mid_rst_pulses", {oStartProcessing, oDoneProcessingFeedback, oResultValid, oPerfect}, 0);
        iReadyToProcess = 0;
        tick();
        iReset_n = 1;
        s0 = n_starts;
        repeat (10) tick();
        chk("no_pulse_after_rst", n_starts, s0);
        chk("idle_after_rst", oState, 0);

`ifdef CHROM_EVAL_WATCHDOG_EN
        load_desc(32'h0400_0000, 31, 1);
        iReadyToProcess = 1;
        wait_start(seen);
        if (seen) begin
            r = '{fit: '1, perf: 0, tmo: 1, l0: 32'hFFFF_FFFF, l7: 32'hFFFF_FFFF};
            res_q.push_back(r);
            s0 = n_fb;
            repeat (20) tick();
            chk("wd_not_yet", oResultValid, 0);
            tick();
            chk("wd_report", oResultValid, 1);
            chk("wd_timeout", oTimeout, 1);
            chk("wd_fitness", oFitness, 35'h7_FFFF_FFFF);
            chk("wd_no_fb", n_fb, s0);
            iResultAck = 1;
            tick();
            iResultAck = 0;
        end
        iReadyToProcess = 0;
`endif

        repeat (3) tick();
        chk("results_drained", res_q.size(), 0);
        chk("descs_drained", desc_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
